decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Pipeline stage directly upstream of the execute stage (register file + ALU).
- Accepts one 32-bit ARM data-processing instruction per cycle and evaluates its condition code against the current flags.
- Produces registered register-file selects, a 5-bit ALU micro-op, an immediate operand and write/flag enables.
- Interlocks conditional instructions that follow a flag-setting instruction by one bubble.

Parameters:
- PC_W, 32, width of pc_in/pc_out.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- instr_in  in  32  instruction word from fetch.
- instr_valid  in  1  instr_in/pc_in valid.
- instr_ready  out  1  combinational; instruction accepted when instr_valid && instr_ready.
- pc_in  in  PC_W  PC of instr_in.
- flags_in  in  4  current architectural flags [3]=Z [2]=C [1]=N [0]=V.
- stall  in  1  downstream hold.
- flush  in  1  discard the decoded instruction.
- out_valid  out  1  decoded fields valid this cycle.
- sel_p0  out  4  Rn (instr[19:16]).
- sel_p1  out  4  Rm (instr[3:0]), 0 when use_imm.
- sel_in  out  4  Rd (instr[15:12]).
- uop  out  5  ALU micro-op.
- imm  out  32  expanded immediate.
- use_imm  out  1  operand 2 is imm.
- write_en  out  1  write result to Rd.
- flags_en  out  1  write ALU flags.
- pc_out  out  PC_W  PC of the decoded instruction.

Behaviour:
- Reset:
  - out_valid, use_imm, write_en and flags_en = 0.
  - sel_p0/sel_p1/sel_in = 0, uop = UOP_NOP, imm = 0, pc_out = 0.
  - FSM = RUN; instr_ready = 0 while reset is high.
- Latency: fields registered one cycle after the accept edge. Throughput is 1/cycle when there is no hazard or stall.
- FSM states: RUN, FLAG_WAIT.
  - RUN: instr_ready = !stall && !hazard.
    - hazard = (out_valid && flags_en) && instr_in[31:28] != AL && instr_valid.
    - On hazard: next state FLAG_WAIT; out_valid <= 0 (bubble).
  - FLAG_WAIT: instr_ready = 0, out_valid <= 0; next state RUN. flags_in is then up to date.
- Priority: reset > flush > stall > accept.
  - flush: out_valid <= 0, state <= RUN; a same-cycle instruction is dropped (instr_ready = 0).
  - stall: all outputs and state hold; instr_ready = 0.
- No accept (valid low) in RUN: out_valid <= 0.
- Format:
  - instr[27:26] must be 00.
  - With I=0, instr[11:4] must be 0 (no register shifts).
  - Otherwise the instruction is undefined: accepted, out_valid <= 0.
- Condition check (combinational, on flags_in):
  - Codes: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL; NV = never.
  - A failed condition gives an accepted bubble (out_valid <= 0).
- Immediate: imm = {24'b0, instr[7:0]} rotated right by 2*instr[11:8], 32-bit wrap.
- Opcode instr[24:21] → uop:
  - AND→UOP_AND, EOR→UOP_EOR, SUB→UOP_SUB, RSB→UOP_RSB, ADD→UOP_ADD, ADC→UOP_ADC.
  - SBC→UOP_SBC, RSC→UOP_RSC, ORR→UOP_ORR, MOV→UOP_MOV, BIC→UOP_BIC, MVN→UOP_MVN.
  - TST/TEQ/CMP/CMN → AND/EOR/SUB/ADD with write_en = 0 and flags_en = 1.
- Other opcodes: write_en = 1, flags_en = S (instr[20]).

Optional Feature:
- Macro: DECODE_UNDEF_FLAG_EN.
- Defined: extra output port undef (1 bit, reset 0) pulses high for exactly one cycle after an undefined instruction is accepted; it follows flush/stall rules like out_valid.
- Undefined: port absent; undefined instructions are silently bubbled.

Decomposition:
- Shared package decode_defs holds:
  - UOP_* constants: NOP 00000, ADD 00001, SUB 00010, RSB 00011, AND 00100, EOR 00101, ORR 00110, BIC 00111, MOV 01000, MVN 01001, ADC 01010, SBC 01011, RSC 01100.
  - COND_* codes.
  - Flag bit indices FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0.
- The ALU uses the same package.
- One sub-module, cond_check: combinational (cond[3:0], flags[3:0]) → pass.

Test Plan:
1. 0xE2812001 (ADD r2,r1,#1) → next cycle: out_valid=1, sel_p0=1, sel_in=2, use_imm=1, imm=1, uop=00001, write_en=1, flags_en=0.
2. 0xE3A034FF (MOV r3,#0xFF000000) → imm=0xFF000000, uop=01000, sel_in=3, write_en=1.
3. 0xE0512000 (SUBS r2,r1,r0), then 0x02844001 (ADDEQ r4,r4,#1):
   - Second instruction sees instr_ready=0 for one cycle, out_valid=0.
   - Then with flags_in=4'b1000: out_valid=1, write_en=1.
   - With flags_in=0000: out_valid=0.
4. 0xE3500005 (CMP r0,#5) → uop=00010, imm=5, write_en=0, flags_en=1.
5. Stall held 3 cycles after 0xE2812001 → outputs unchanged, instr_ready=0. Flush with stall → out_valid=0 next cycle; flush wins.
6. 0xEA000000 (branch) → accepted, out_valid=0; with DECODE_UNDEF_FLAG_EN, undef=1 for exactly one cycle. Mid-stream reset → all outputs at reset values next cycle.

Source files
------------

// File: rtl/decode_defs.sv
// Shared definitions for the decode stage and the ALU downstream of it:
// micro-op encodings, ARM condition codes, flag bit positions, the
// decode FSM state type and the immediate-expansion helper.
package decode_defs;

  // ALU micro-op encodings
  localparam logic [4:0] UOP_NOP = 5'b00000;
  localparam logic [4:0] UOP_ADD = 5'b00001;
  localparam logic [4:0] UOP_SUB = 5'b00010;
  localparam logic [4:0] UOP_RSB = 5'b00011;
  localparam logic [4:0] UOP_AND = 5'b00100;
  localparam logic [4:0] UOP_EOR = 5'b00101;
  localparam logic [4:0] UOP_ORR = 5'b00110;
  localparam logic [4:0] UOP_BIC = 5'b00111;
  localparam logic [4:0] UOP_MOV = 5'b01000;
  localparam logic [4:0] UOP_MVN = 5'b01001;
  localparam logic [4:0] UOP_ADC = 5'b01010;
  localparam logic [4:0] UOP_SBC = 5'b01011;
  localparam logic [4:0] UOP_RSC = 5'b01100;

  // ARM condition field encodings (instr[31:28])
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Bit positions inside the 4-bit flags vector
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  // Decode interlock FSM
  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_FLAG_WAIT = 1'b1
  } state_t;

  // Rotate an 8-bit immediate right by twice the 4-bit rotate field.
  // The value is doubled up so the shift wraps without a 32-bit shift count.
  function automatic logic [31:0] expand_imm(input logic [11:0] field);
    logic [63:0] doubled;
    logic [4:0]  amount;
    doubled = {24'b0, field[7:0], 24'b0, field[7:0]};
    amount  = {field[11:8], 1'b0};
    doubled = doubled >> amount;
    return doubled[31:0];
  endfunction

endpackage

// File: rtl/decode_stage_cond_check.sv
// Combinational ARM condition-code evaluator: pass is high when the
// instruction with condition field cond should execute under flags.
module cond_check
  import decode_defs::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic z, c, n, v;

  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];

  // Map each condition code onto its flag predicate; NV never executes
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage for ARM data-processing instructions. Evaluates the
// condition code, expands the rotated immediate, maps the opcode to an
// ALU micro-op and registers all fields for the execute stage. A
// conditional instruction directly behind a flag-setting one waits one
// bubble (FLAG_WAIT) so it sees the updated flags.
// Optional feature macro: DECODE_UNDEF_FLAG_EN adds the 'undef' output.
module decode_stage
  import decode_defs::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     instr_in,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [PC_W-1:0] pc_in,
  input  logic [3:0]      flags_in,
  input  logic            stall,
  input  logic            flush,
  output logic            out_valid,
  output logic [3:0]      sel_p0,
  output logic [3:0]      sel_p1,
  output logic [3:0]      sel_in,
  output logic [4:0]      uop,
  output logic [31:0]     imm,
  output logic            use_imm,
  output logic            write_en,
  output logic            flags_en,
  output logic [PC_W-1:0] pc_out
`ifdef DECODE_UNDEF_FLAG_EN
  ,
  output logic            undef
`endif
);

  state_t      state, state_next;
  logic        hazard, accept, fmt_ok, cond_pass;
  logic [3:0]  cond, opcode;
  logic        imm_flag, s_bit;
  logic [4:0]  d_uop;
  logic        d_write_en, d_flags_en;
  logic [31:0] d_imm;
  logic [3:0]  d_sel_p1;

  assign cond     = instr_in[31:28];
  assign imm_flag = instr_in[25];
  assign opcode   = instr_in[24:21];
  assign s_bit    = instr_in[20];

  // Register-shifted and non-data-processing encodings are undefined here
  assign fmt_ok = (instr_in[27:26] == 2'b00) && (imm_flag || (instr_in[11:4] == 8'd0));

  // A conditional instruction cannot use flags still being produced downstream
  assign hazard = out_valid && flags_en && (cond != COND_AL) && instr_valid;

  assign accept = instr_valid && instr_ready;

  cond_check u_cond_check (
    .cond  (cond),
    .flags (flags_in),
    .pass  (cond_pass)
  );

  // Interlock FSM state register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  // Next state and handshake: flush beats stall, stall beats the hazard bubble
  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    case (state)
      ST_RUN: begin
        instr_ready = !stall && !hazard && !flush && !reset;
        if (hazard) state_next = ST_FLAG_WAIT;
      end
      ST_FLAG_WAIT: begin
        state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
    if (flush)      state_next = ST_RUN;
    else if (stall) state_next = state;
  end

  // Opcode to micro-op; compare/test forms only update flags
  always_comb begin
    d_uop      = UOP_NOP;
    d_write_en = 1'b1;
    d_flags_en = s_bit;
    case (opcode)
      4'b0000: d_uop = UOP_AND;
      4'b0001: d_uop = UOP_EOR;
      4'b0010: d_uop = UOP_SUB;
      4'b0011: d_uop = UOP_RSB;
      4'b0100: d_uop = UOP_ADD;
      4'b0101: d_uop = UOP_ADC;
      4'b0110: d_uop = UOP_SBC;
      4'b0111: d_uop = UOP_RSC;
      4'b1000: begin d_uop = UOP_AND; d_write_en = 1'b0; d_flags_en = 1'b1; end
      4'b1001: begin d_uop = UOP_EOR; d_write_en = 1'b0; d_flags_en = 1'b1; end
      4'b1010: begin d_uop = UOP_SUB; d_write_en = 1'b0; d_flags_en = 1'b1; end
      4'b1011: begin d_uop = UOP_ADD; d_write_en = 1'b0; d_flags_en = 1'b1; end
      4'b1100: d_uop = UOP_ORR;
      4'b1101: d_uop = UOP_MOV;
      4'b1110: d_uop = UOP_BIC;
      4'b1111: d_uop = UOP_MVN;
      default: d_uop = UOP_NOP;
    endcase
  end

  // Operand 2 is either the rotated immediate or register Rm, never both
  always_comb begin
    d_imm    = 32'd0;
    d_sel_p1 = instr_in[3:0];
    if (imm_flag) begin
      d_imm    = expand_imm(instr_in[11:0]);
      d_sel_p1 = 4'd0;
    end
  end

  // Output register: undefined or condition-failed instructions become bubbles
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      sel_p0    <= 4'd0;
      sel_p1    <= 4'd0;
      sel_in    <= 4'd0;
      uop       <= UOP_NOP;
      imm       <= 32'd0;
      use_imm   <= 1'b0;
      write_en  <= 1'b0;
      flags_en  <= 1'b0;
      pc_out    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      if (accept) begin
        out_valid <= fmt_ok && cond_pass;
        sel_p0    <= instr_in[19:16];
        sel_p1    <= d_sel_p1;
        sel_in    <= instr_in[15:12];
        uop       <= d_uop;
        imm       <= d_imm;
        use_imm   <= imm_flag;
        write_en  <= d_write_en;
        flags_en  <= d_flags_en;
        pc_out    <= pc_in;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef DECODE_UNDEF_FLAG_EN
  // One-cycle pulse after an undefined instruction is accepted
  always_ff @(posedge clock) begin
    if (reset)       undef <= 1'b0;
    else if (flush)  undef <= 1'b0;
    else if (!stall) undef <= accept && !fmt_ok;
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_in;
  logic [3:0]  flags_in;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic [3:0]  sel_p0, sel_p1, sel_in;
  logic [4:0]  uop;
  logic [31:0] imm;
  logic        use_imm, write_en, flags_en;
  logic [31:0] pc_out;
`ifdef DECODE_UNDEF_FLAG_EN
  logic        undef;
`endif

  int checks = 0;
  int failures = 0;

  decode_stage #(.PC_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_in       (pc_in),
    .flags_in    (flags_in),
    .stall       (stall),
    .flush       (flush),
    .out_valid   (out_valid),
    .sel_p0      (sel_p0),
    .sel_p1      (sel_p1),
    .sel_in      (sel_in),
    .uop         (uop),
    .imm         (imm),
    .use_imm     (use_imm),
    .write_en    (write_en),
    .flags_en    (flags_en),
    .pc_out      (pc_out)
`ifdef DECODE_UNDEF_FLAG_EN
    ,
    .undef       (undef)
`endif
  );

  always #5 clock = ~clock;

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic valid);
    instr_in    = instr;
    pc_in       = pc;
    instr_valid = valid;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; flags_in = 4'b0000;
    drive(32'hE2812001, 32'h0000_0010, 1'b1);
    checks++; if (instr_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 0", instr_ready); end
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (uop !== 5'b00000) begin failures++; $display("[TB] FAIL reset_uop: got %b expected 00000", uop); end
    checks++; if ({sel_p0, sel_p1, sel_in} !== 12'h000) begin failures++; $display("[TB] FAIL reset_sels: got %h expected 000", {sel_p0, sel_p1, sel_in}); end
    checks++; if (imm !== 32'd0 || pc_out !== 32'd0) begin failures++; $display("[TB] FAIL reset_imm_pc: got %h/%h expected 0/0", imm, pc_out); end
    checks++; if ({use_imm, write_en, flags_en} !== 3'b000) begin failures++; $display("[TB] FAIL reset_enables: got %b expected 000", {use_imm, write_en, flags_en}); end
    drive(32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add_imm();
    drive(32'hE2812001, 32'h0000_0100, 1'b1);
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("[TB] FAIL add_ready: got %b expected 1", instr_ready); end
    tick();
    drive(32'h0, 32'h0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL add_valid: got %b expected 1", out_valid); end
    checks++; if ({sel_p0, sel_p1, sel_in} !== 12'h102) begin failures++; $display("[TB] FAIL add_sels: got %h expected 102", {sel_p0, sel_p1, sel_in}); end
    checks++; if (uop !== 5'b00001 || imm !== 32'd1) begin failures++; $display("[TB] FAIL add_uop_imm: got %b/%h expected 00001/00000001", uop, imm); end
    checks++; if ({use_imm, write_en, flags_en} !== 3'b110) begin failures++; $display("[TB] FAIL add_enables: got %b expected 110", {use_imm, write_en, flags_en}); end
    checks++; if (pc_out !== 32'h0000_0100) begin failures++; $display("[TB] FAIL add_pc: got %h expected 00000100", pc_out); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_valid: got %b expected 0", out_valid); end
  endtask

  // Back-to-back MOVs exercising the immediate rotation, including wrap
  task automatic test_back_to_back();
    logic [31:0] instrs [3];
    logic [31:0] imms   [3];
    instrs[0] = 32'hE3A034FF; imms[0] = 32'hFF00_0000;
    instrs[1] = 32'hE3A00F01; imms[1] = 32'h0000_0004;
    instrs[2] = 32'hE3A00102; imms[2] = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      drive(instrs[i], 32'h200 + 32'(i * 4), 1'b1);
      checks++; if (instr_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready[%0d]: got %b expected 1", i, instr_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || uop !== 5'b01000 || write_en !== 1'b1) begin failures++; $display("[TB] FAIL b2b_mov[%0d]: got v=%b uop=%b we=%b expected 1/01000/1", i, out_valid, uop, write_en); end
      checks++; if (imm !== imms[i]) begin failures++; $display("[TB] FAIL b2b_imm[%0d]: got %h expected %h", i, imm, imms[i]); end
    end
    checks++; if (sel_in !== 4'd0 || pc_out !== 32'h208) begin failures++; $display("[TB] FAIL b2b_last: got rd=%0d pc=%h expected 0/208", sel_in, pc_out); end
    drive(32'h0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_flag_hazard();
    bit ready_seen;
    flags_in = 4'b1000;
    drive(32'hE0512000, 32'h300, 1'b1);
    tick();
    checks++; if (out_valid !== 1'b1 || uop !== 5'b00010 || flags_en !== 1'b1 || write_en !== 1'b1) begin failures++; $display("[TB] FAIL subs_fields: got v=%b uop=%b fe=%b we=%b expected 1/00010/1/1", out_valid, uop, flags_en, write_en); end
    checks++; if (use_imm !== 1'b0 || sel_p1 !== 4'd0 || sel_p0 !== 4'd1) begin failures++; $display("[TB] FAIL subs_regs: got ui=%b rm=%0d rn=%0d expected 0/0/1", use_imm, sel_p1, sel_p0); end
    drive(32'h02844001, 32'h304, 1'b1);
    checks++; if (instr_ready !== 1'b0) begin failures++; $display("[TB] FAIL hazard_ready: got %b expected 0", instr_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL hazard_bubble: got %b expected 0", out_valid); end
    ready_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (instr_ready === 1'b1) begin ready_seen = 1'b1; break; end
      tick();
    end
    checks++; if (!ready_seen) begin failures++; $display("[TB] FAIL hazard_release: got ready=%b expected 1 within 4 cycles", instr_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || write_en !== 1'b1 || sel_in !== 4'd4 || imm !== 32'd1) begin failures++; $display("[TB] FAIL addeq_pass: got v=%b we=%b rd=%0d imm=%h expected 1/1/4/1", out_valid, write_en, sel_in, imm); end
    flags_in = 4'b0000;
    drive(32'h02844001, 32'h308, 1'b1);
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("[TB] FAIL addeq2_ready: got %b expected 1", instr_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL addeq_fail: got %b expected 0", out_valid); end
    drive(32'h0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_cmp();
    drive(32'hE3500005, 32'h400, 1'b1);
    tick();
    drive(32'h0, 32'h0, 1'b0);
    checks++; if (out_valid !== 1'b1 || uop !== 5'b00010 || imm !== 32'd5) begin failures++; $display("[TB] FAIL cmp_fields: got v=%b uop=%b imm=%h expected 1/00010/5", out_valid, uop, imm); end
    checks++; if (write_en !== 1'b0 || flags_en !== 1'b1) begin failures++; $display("[TB] FAIL cmp_enables: got we=%b fe=%b expected 0/1", write_en, flags_en); end
    tick();
  endtask

  task automatic test_stall_flush();
    drive(32'hE2812001, 32'h500, 1'b1);
    tick();
    stall = 1'b1;
    drive(32'hE3A034FF, 32'h504, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (instr_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_ready[%0d]: got %b expected 0", i, instr_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || uop !== 5'b00001 || imm !== 32'd1 || pc_out !== 32'h500) begin failures++; $display("[TB] FAIL stall_hold[%0d]: got v=%b uop=%b imm=%h pc=%h expected 1/00001/1/500", i, out_valid, uop, imm, pc_out); end
    end
    flush = 1'b1;
    #1;
    checks++; if (instr_ready !== 1'b0) begin failures++; $display("[TB] FAIL flush_ready: got %b expected 0", instr_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_wins: got %b expected 0", out_valid); end
    flush = 1'b0; stall = 1'b0;
    drive(32'h0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_undefined();
    drive(32'hEA000000, 32'h600, 1'b1);
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("[TB] FAIL branch_ready: got %b expected 1", instr_ready); end
    tick();
    drive(32'h0, 32'h0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL branch_bubble: got %b expected 0", out_valid); end
`ifdef DECODE_UNDEF_FLAG_EN
    checks++; if (undef !== 1'b1) begin failures++; $display("[TB] FAIL undef_pulse: got %b expected 1", undef); end
    tick();
    checks++; if (undef !== 1'b0) begin failures++; $display("[TB] FAIL undef_clear: got %b expected 0", undef); end
`endif
    drive(32'hE0812010, 32'h604, 1'b1);
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL regshift_bubble: got %b expected 0", out_valid); end
    drive(32'hF2812001, 32'h608, 1'b1);
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL nv_bubble: got %b expected 0", out_valid); end
    drive(32'h0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_mid_reset();
    drive(32'hE2812001, 32'h700, 1'b1);
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL prereset_valid: got %b expected 1", out_valid); end
    reset = 1'b1;
    #1;
    checks++; if (instr_ready !== 1'b0) begin failures++; $display("[TB] FAIL midreset_ready: got %b expected 0", instr_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || uop !== 5'b00000 || imm !== 32'd0 || pc_out !== 32'd0) begin failures++; $display("[TB] FAIL midreset_outs: got v=%b uop=%b imm=%h pc=%h expected 0/00000/0/0", out_valid, uop, imm, pc_out); end
    checks++; if ({sel_p0, sel_p1, sel_in} !== 12'h000 || {use_imm, write_en, flags_en} !== 3'b000) begin failures++; $display("[TB] FAIL midreset_fields: got sels=%h en=%b expected 000/000", {sel_p0, sel_p1, sel_in}, {use_imm, write_en, flags_en}); end
    reset = 1'b0;
    drive(32'h0, 32'h0, 1'b0);
    tick();
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_back_to_back();
    test_flag_hazard();
    test_cmp();
    test_stall_flush();
    test_undefined();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "[TB] timeout");
  end

endmodule
